// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_search_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRIAL  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Bit-index width; a 1-bit operand still needs a 1-bit index register.
  function automatic int sar_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// SAR search controller: drives comparator operand a (guess) and resolves the
// unknown b operand from the lesser/greater/equal flags, MSB first.
module sar_search_ctrl
  import sar_search_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         lesser,
  input  logic         greater,
  input  logic         equal,
  output logic [N-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         error,
  output logic [N-1:0] result
);

  localparam int IW = sar_clog2(N);

  state_e          r_state;
  logic [N-1:0]    r_acc;
  logic [N-1:0]    r_result;
  logic [IW-1:0]   r_idx;
  logic            r_busy, r_done, r_found, r_error;

  logic [N-1:0]    w_mask;
  logic [N-1:0]    w_trial;
  logic            w_onehot;

  assign w_mask   = {{(N-1){1'b0}}, 1'b1} << r_idx;
  assign w_trial  = r_acc | w_mask;
  assign w_onehot = $onehot({lesser, greater, equal});

  always_comb begin
    guess = r_result;
    case (r_state)
      S_TRIAL:  guess = w_trial;
      S_VERIFY: guess = r_acc;
      default:  guess = r_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_idx   <= IW'(N-1);
            r_found <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_TRIAL;
          end
        end
        S_TRIAL: begin
          if (!w_onehot) begin
            r_error  <= 1'b1;
            r_result <= r_acc;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (equal) begin
            r_acc    <= w_trial;
            r_result <= w_trial;
            r_found  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            if (lesser) r_acc <= w_trial;
            if (r_idx == '0) r_state <= S_VERIFY;
            else             r_idx   <= r_idx - 1'b1;
          end
        end
        S_VERIFY: begin
          // Only reached for target 0 or a target that moved mid-search.
          r_result <= r_acc;
          r_found  <= equal;
          r_error  <= !w_onehot;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign found  = r_found;
  assign error  = r_error;
  assign result = r_result;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: behavioural comparator on the DUT, binary-search
// reference model, directed scenarios plus random targets.
module tb_sar_search_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         lesser, greater, equal;
  logic [N-1:0] guess, result;
  logic         busy, done, found, error;

  logic [N-1:0] target = '0;
  logic         ovr_en = 1'b0;
  logic [2:0]   ovr_flags = 3'b000;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Magnitude comparator: a = guess, b = target; flags can be overridden.
  always_comb begin
    if (ovr_en) {lesser, greater, equal} = ovr_flags;
    else        {lesser, greater, equal} = {guess < target, guess > target, guess == target};
  end

  sar_search_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .lesser(lesser), .greater(greater), .equal(equal),
    .guess(guess), .busy(busy), .done(done), .found(found),
    .error(error), .result(result)
  );

  // Reference model: plain binary search over the value range.
  int           exp_n;
  logic [N-1:0] exp_seq [0:15];
  logic [N-1:0] exp_res;
  logic         exp_found;

  function automatic void ref_search(input int t);
    int acc, g;
    acc = 0;
    exp_n = 0;
    for (int i = N-1; i >= 0; i--) begin
      g = acc + (1 << i);
      exp_seq[exp_n] = N'(g);
      exp_n++;
      if (g == t) begin
        exp_res = N'(g);
        exp_found = 1'b1;
        return;
      end
      if (g < t) acc = g;
    end
    exp_seq[exp_n] = N'(acc);
    exp_n++;
    exp_res = N'(acc);
    exp_found = (acc == t);
  endfunction

  // Observations of one search run.
  int           obs_n;
  logic [N-1:0] obs_seq [0:31];
  int           obs_dones;
  logic [N-1:0] obs_res;
  logic         obs_found, obs_err;

  // inj_cyc: busy cycle to override flags; sb_cyc: busy cycle to re-pulse start.
  task automatic do_search(input logic [N-1:0] t, input int inj_cyc, input logic [2:0] inj_flags,
                           input int sb_cyc, input bit start_in_done);
    target = t;
    obs_n = 0; obs_dones = 0; obs_res = 'x; obs_found = 1'bx; obs_err = 1'bx;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      ovr_en = 1'b0;
      if (busy) begin
        obs_seq[obs_n] = guess;
        obs_n++;
        if (obs_n == inj_cyc) begin ovr_en = 1'b1; ovr_flags = inj_flags; end
        if (obs_n == sb_cyc) start = 1'b1;
      end
      if (done) begin
        obs_dones++;
        obs_res = result; obs_found = found; obs_err = error;
        if (start_in_done) start = 1'b1;
      end
    end
    start = 1'b0;
    ovr_en = 1'b0;
  endtask

  task automatic check_search(input string nm);
    bit seq_ok;
    seq_ok = 1'b1;
    for (int i = 0; i < exp_n && i < obs_n; i++)
      if (obs_seq[i] !== exp_seq[i]) seq_ok = 1'b0;
    n_tests++;
    if (obs_n != exp_n || !seq_ok) begin
      n_fail++;
      $display("FAIL %s busy/seq: got %0d cycles (first guess %h), want %0d (first %h)",
               nm, obs_n, obs_seq[0], exp_n, exp_seq[0]);
    end
    n_tests++;
    if (obs_dones != 1) begin
      n_fail++; $display("FAIL %s done_count: got %0d want 1", nm, obs_dones);
    end
    n_tests++;
    if (obs_res !== exp_res || obs_found !== exp_found || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s outcome: got res=%h found=%b err=%b want res=%h found=%b err=0",
               nm, obs_res, obs_found, obs_err, exp_res, exp_found);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({guess, result, busy, done, found, error} !== '0) begin
      n_fail++;
      $display("FAIL reset: got g=%h r=%h b=%b d=%b f=%b e=%b want all 0",
               guess, result, busy, done, found, error);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_msb();
    ref_search(8'h80);
    do_search(8'h80, 0, 3'b000, 0, 1'b0);
    check_search("msb_80");
    n_tests++;
    if (obs_n != 1 || obs_seq[0] !== 8'h80) begin
      n_fail++; $display("FAIL msb_single_trial: got n=%0d g=%h want n=1 g=80", obs_n, obs_seq[0]);
    end
  endtask

  task automatic test_a5();
    logic [N-1:0] want [0:7];
    bit ok;
    want = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    ref_search(8'hA5);
    do_search(8'hA5, 0, 3'b000, 0, 1'b0);
    check_search("seq_a5");
    ok = (obs_n == 8);
    for (int i = 0; i < 8; i++) if (obs_seq[i] !== want[i]) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL a5_sequence: got n=%0d last=%h want n=8 last=a5", obs_n, obs_seq[7]);
    end
  endtask

  task automatic test_zero();
    ref_search(0);
    do_search(8'h00, 0, 3'b000, 0, 1'b0);
    check_search("zero");
    n_tests++;
    if (obs_n != 9 || obs_seq[8] !== 8'h00 || obs_found !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_verify: got n=%0d vg=%h found=%b want 9 00 1", obs_n, obs_seq[8], obs_found);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] t;
    for (int k = 0; k < 20; k++) begin
      t = N'($urandom_range(0, 255));
      ref_search(int'(t));
      do_search(t, 0, 3'b000, 0, 1'b0);
      check_search($sformatf("rand_%h", t));
    end
  endtask

  task automatic test_flag_error();
    do_search(8'hA5, 3, 3'b000, 0, 1'b0);
    n_tests++;
    if (obs_n != 3 || obs_dones != 1 || obs_err !== 1'b1 || obs_found !== 1'b0 || obs_res !== 8'h80) begin
      n_fail++;
      $display("FAIL flags_none: got n=%0d d=%0d err=%b found=%b res=%h want 3 1 1 0 80",
               obs_n, obs_dones, obs_err, obs_found, obs_res);
    end
    do_search(8'h3C, 2, 3'b101, 0, 1'b0);
    n_tests++;
    if (obs_n != 2 || obs_err !== 1'b1 || obs_found !== 1'b0 || obs_res !== 8'h00) begin
      n_fail++;
      $display("FAIL flags_multi: got n=%0d err=%b found=%b res=%h want 2 1 0 00",
               obs_n, obs_err, obs_found, obs_res);
    end
  endtask

  task automatic test_back_to_back();
    ref_search(8'h5A);
    do_search(8'h5A, 0, 3'b000, 3, 1'b1);
    check_search("start_ignored");
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL start_in_done: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int n, dn;
    bit armed;
    target = 8'h3C;
    n = 0; dn = 0; armed = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 12 && !armed; c++) begin
      @(negedge clk);
      if (busy) n++;
      if (done) dn++;
      if (n == 4) armed = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (!armed || {guess, result, busy, done, found, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got armed=%b g=%h r=%h b=%b d=%b f=%b e=%b want all 0",
               armed, guess, result, busy, done, found, error);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    n_tests++;
    if (dn != 0) begin
      n_fail++; $display("FAIL reset_no_done: got %0d activity cycles want 0", dn);
    end
    ref_search(8'h3C);
    do_search(8'h3C, 0, 3'b000, 0, 1'b0);
    check_search("after_reset_3c");
  endtask

  initial begin
    test_reset();
    test_msb();
    test_a5();
    test_zero();
    test_flag_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
Successive-approximation search controller that drives the guess operand of an external N-bit magnitude comparator and consumes its lesser/greater/equal flags. It finds an unknown target value in at most N+1 compare cycles.
It is the driving side of the team's comparator interface: the comparator's a input is tied to guess and its b input to the target. Typical uses are threshold search, SAR ADC control and test stimulus generation.

Parameters:
N, 8, operand width in bits; applies to guess, result and the comparator operands.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new search; sampled only in IDLE.
lesser  input  1  comparator flag: guess < target.
greater  input  1  comparator flag: guess > target.
equal  input  1  comparator flag: guess == target.
guess  output  N  trial value presented to the comparator a input.
busy  output  1  high in TRIAL and VERIFY.
done  output  1  one-cycle pulse when the search completes.
found  output  1  exact match confirmed; valid from done, held until next start.
error  output  1  inconsistent comparator flags; valid from done, held until next start.
result  output  N  search result; valid from done, held until next start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; guess, result, acc, idx, busy, done, found and error all 0.
- Comparator is combinational: flags for the current guess are sampled on the same rising edge.
- Registers: acc[N-1:0] (accumulated result) and idx (bit index, width clog2(N), minimum 1).
- States: IDLE, TRIAL, VERIFY, DONE.
- IDLE:
  - guess = result.
  - On start=1: acc<=0, idx<=N-1, found<=0, error<=0, go to TRIAL.
  - A start while not in IDLE is ignored (no queuing).
- TRIAL:
  - guess = acc | (1<<idx), combinational from registers.
  - Flag check: flags must be exactly one-hot. If not (none or several set): error<=1, result<=acc, go to DONE.
  - equal: acc<=guess, result<=guess, found<=1, go to DONE (early exit).
  - lesser: acc<=guess (keep bit).
  - greater: acc unchanged (drop bit).
  - After lesser/greater: if idx==0 go to VERIFY, else idx<=idx-1.
- VERIFY:
  - guess = acc.
  - result<=acc; found<=equal; error<=1 if flags are not one-hot; go to DONE.
  - VERIFY is only reached when the target is 0 or the target changed mid-search.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next state IDLE.
  - start in DONE is ignored.
- Latency: let k be the lowest set bit of the target. TRIAL cycles = N-k; target 0 takes N TRIAL cycles plus 1 VERIFY cycle. done is high in the cycle after the final compare edge.
- Target changing mid-search: no protection. The search completes normally, and found=0 if the VERIFY compare mismatches.
- Reset mid-search: immediate return to the reset values; no done pulse.
- Outputs are registered, except guess, which is combinational from state, acc and idx.

Decomposition:
- Shared package/header sar_search_pkg:
  - State encoding localparams S_IDLE=2'd0, S_TRIAL=2'd1, S_VERIFY=2'd2, S_DONE=2'd3.
  - A clog2 function for sizing idx.
- No sub-module. The one-hot bit mask is a shift expression.
- The bench pairs the DUT with the team's existing N-bit magnitude comparator, with target on b.

Test Plan:
1. N=8, target=0x80, pulse start → one TRIAL cycle (guess=0x80), equal; done next cycle; result=0x80, found=1, error=0.
2. target=0xA5 → guess sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; done after 8 TRIAL cycles; result=0xA5, found=1.
3. target=0x00 → 8 TRIAL cycles, all greater; VERIFY guess=0x00, equal; result=0x00, found=1, 9 busy cycles.
4. Force the flags to 3'b000 during the 3rd TRIAL → done next cycle; error=1, found=0, result=acc at that point (0x80 for target=0xA5).
5. Pulse start during busy, and again in the DONE cycle → both ignored; busy stays high; exactly one done pulse.
6. Assert rst_n=0 mid-search (4th TRIAL, target=0x3C) → all outputs 0 immediately, state IDLE, no done. After release, start runs a clean search: result=0x3C, found=1.
